// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared arbiter state encoding and the side identifiers used for the round-robin last flag.
package mux_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GX = 2'b01, GY = 2'b10} state_e;
  localparam logic SIDE_X = 1'b0;
  localparam logic SIDE_Y = 1'b1;
endpackage

// File: rtl/mux2_nbit.sv
// mux2_nbit: N-bit 2-to-1 AND-OR select, s=0 picks X, s=1 picks Y.
module mux2_nbit #(
  parameter int N = 4
) (
  input  logic         s,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] M
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign M[i] = (~s & X[i]) | (s & Y[i]);
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter with a bounded hold that owns the select of a shared N-bit mux.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         req_x,
  input  logic         req_y,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         gnt_x,
  output logic         gnt_y,
  output logic         s,
  output logic [N-1:0] M,
  output logic         valid
);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [N-1:0]  mux_m;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SIDE_Y;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
  // On release the other side wins if it is asking, so ownership hands over without an idle bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: state_d = (req_x && (!req_y || last_q == SIDE_Y)) ? GX : req_y ? GY : IDLE;
      GX: begin
        if (req_x && cnt_q < HOLD_LIM) cnt_d = cnt_q + CW'(1);
        else begin
          last_d  = SIDE_X;
          cnt_d   = '0;
          state_d = req_y ? GY : req_x ? GX : IDLE;
        end
      end
      GY: begin
        if (req_y && cnt_q < HOLD_LIM) cnt_d = cnt_q + CW'(1);
        else begin
          last_d  = SIDE_Y;
          cnt_d   = '0;
          state_d = req_x ? GX : req_y ? GY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign gnt_x = (state_q == GX);
  assign gnt_y = (state_q == GY);
  assign s     = gnt_y;
  assign valid = gnt_x | gnt_y;
  mux2_nbit #(.N(N)) u_mux (.s(s), .X(X), .Y(Y), .M(mux_m));
  assign M = {N{valid}} & mux_m;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and random stimulus on MAX_HOLD=4 and MAX_HOLD=1 arbiters against a round-robin reference model.
module tb_mux_arbiter;
  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       req_x = 1'b0, req_y = 1'b0;
  logic [3:0] X = 4'h0, Y = 4'h0;
  logic       gx_a, gy_a, s_a, v_a, gx_b, gy_b, s_b, v_b;
  logic [3:0] m_a, m_b;
  int vectors = 0, miscompares = 0;
  int own_a = 0, held_a = 0, last_a = 2;
  int own_b = 0, held_b = 0, last_b = 2;

  always #5 Clock = ~Clock;

  mux_arbiter #(.N(4), .MAX_HOLD(4)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .req_x(req_x), .req_y(req_y), .X(X), .Y(Y),
    .gnt_x(gx_a), .gnt_y(gy_a), .s(s_a), .M(m_a), .valid(v_a));
  mux_arbiter #(.N(4), .MAX_HOLD(1)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .req_x(req_x), .req_y(req_y), .X(X), .Y(Y),
    .gnt_x(gx_b), .gnt_y(gy_b), .s(s_b), .M(m_b), .valid(v_b));

  // Owner: 0 none, 1 X, 2 Y. held counts cycles served in the current grant.
  task automatic model_step(input int maxh, input logic rx, input logic ry,
                            inout int own, inout int held, inout int last);
    if (own != 0 && ((own == 1) ? rx : ry) && held < maxh) held++;
    else begin
      if (own != 0) last = own;
      own  = (rx && ry) ? 3 - last : rx ? 1 : ry ? 2 : 0;
      held = (own != 0) ? 1 : 0;
    end
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".a.gnt_x"}, {3'b0, gx_a}, {3'b0, own_a == 1});
    cmp({tag, ".a.gnt_y"}, {3'b0, gy_a}, {3'b0, own_a == 2});
    cmp({tag, ".a.s"},     {3'b0, s_a},  {3'b0, own_a == 2});
    cmp({tag, ".a.valid"}, {3'b0, v_a},  {3'b0, own_a != 0});
    cmp({tag, ".a.M"}, m_a, own_a == 1 ? X : own_a == 2 ? Y : 4'h0);
    cmp({tag, ".b.gnt_x"}, {3'b0, gx_b}, {3'b0, own_b == 1});
    cmp({tag, ".b.gnt_y"}, {3'b0, gy_b}, {3'b0, own_b == 2});
    cmp({tag, ".b.s"},     {3'b0, s_b},  {3'b0, own_b == 2});
    cmp({tag, ".b.valid"}, {3'b0, v_b},  {3'b0, own_b != 0});
    cmp({tag, ".b.M"}, m_b, own_b == 1 ? X : own_b == 2 ? Y : 4'h0);
  endtask

  task automatic model_reset();
    own_a = 0; held_a = 0; last_a = 2;
    own_b = 0; held_b = 0; last_b = 2;
  endtask

  task automatic cycle(input string tag);
    @(posedge Clock);
    model_step(4, req_x, req_y, own_a, held_a, last_a);
    model_step(1, req_x, req_y, own_b, held_b, last_b);
    #1 check_all(tag);
  endtask

  initial begin
    #12 check_all("reset");
    Resetn = 1'b1;
    req_x = 1'b1; X = 4'hA; Y = 4'h5;
    for (int k = 0; k < 6; k++) cycle("x_only");
    req_x = 1'b0;
    for (int k = 0; k < 2; k++) cycle("x_drop");
    req_x = 1'b1; req_y = 1'b1; X = 4'h3; Y = 4'hC;
    for (int k = 0; k < 10; k++) cycle("contend");
    for (int k = 0; k < 8 && own_a != 2; k++) cycle("to_gy");
    req_y = 1'b0;
    cycle("handover");
    cmp("handover.gnt_x", {3'b0, gx_a}, 4'h1);
    cmp("handover.M", m_a, 4'h3);
    req_x = 1'b0; X = 4'hF;
    cycle("drop_idle");
    cmp("drop_idle.M", m_a, 4'h0);
    req_x = 1'b1;
    cycle("pre_rst");
    req_y = 1'b1;
    #3 Resetn = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #2 Resetn = 1'b1;
    cycle("post_rst");
    cmp("post_rst.x_first", {3'b0, gx_a}, 4'h1);
    for (int k = 0; k < 6; k++) cycle("alternate");
    for (int k = 0; k < 300; k++) begin
      req_x = 1'($urandom_range(0, 3) != 0);
      req_y = 1'($urandom_range(0, 3) != 0);
      X = 4'($urandom);
      Y = 4'($urandom);
      cycle("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
Two-requester round-robin arbiter that shares the N-bit 2-to-1 multiplexer datapath between source X and source Y.
- Owns the select line; drives the muxed result onto M.
- Tells each requester when its data is on the output.
- Sits between the switch/register sources and the LED/downstream consumer in the lab top level.

Parameters:
N, 4, data width of each source and of M
MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (>=1)

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
req_x  input  1  source X requests the output
req_y  input  1  source Y requests the output
X  input  N  source X data
Y  input  N  source Y data
gnt_x  output  1  X currently owns the output
gnt_y  output  1  Y currently owns the output
s  output  1  mux select: 0 = X, 1 = Y
M  output  N  muxed data
valid  output  1  M carries granted data (gnt_x | gnt_y)

Behaviour:
- Reset:
  - Asynchronous on Resetn=0.
  - state=IDLE, cnt=0, last=Y, so X wins the first tie.
  - gnt_x=gnt_y=0, s=0, valid=0, M=0.
  - Reset asserted mid-grant drops the grant immediately, not at the next edge.
- States: IDLE, GX, GY. Grants are decoded from the registered state: gnt_x=(state==GX), gnt_y=(state==GY).
- Latency: a grant is asserted on the first rising edge after the request is sampled high (1 cycle).
- IDLE transitions:
  - req_x only -> GX.
  - req_y only -> GY.
  - Both -> the side not equal to last.
  - Neither -> stay in IDLE.
- GX, with next_cnt = cnt+1:
  - If req_x=1 and cnt < MAX_HOLD-1: stay in GX, cnt <= next_cnt.
  - Otherwise the grant releases (req_x dropped or hold expired); last <= X, cnt <= 0. Next state:
    - GY if req_y=1. No idle bubble between owners.
    - Else GX if req_x=1 (hold expired, no contender: re-grant with count restarted).
    - Else IDLE.
- GY is symmetric with X and Y swapped; last <= Y on release.
- Simultaneous events:
  - Owner drops its request in the same cycle the other side raises its own: switch owner on the next edge.
  - Both sides drop in the same cycle: go to IDLE.
- MAX_HOLD=1: every grant lasts exactly one cycle; under continuous contention the grants alternate X, Y, X, ...
- Datapath (combinational from state):
  - s = (state==GY).
  - M = s ? Y : X when valid, else all zeros.
  - Per bit: M[i] = valid & ((~s & X[i]) | (s & Y[i])).
- Widths:
  - cnt is max(1, $clog2(MAX_HOLD)) bits.
  - The cnt comparison is unsigned.
  - cnt never exceeds MAX_HOLD-1 and never wraps.
- Requesters must hold X/Y stable while granted. The arbiter does not register the data; a data change appears on M in the same cycle.
- A requester that is not granted may drop its request at any time; it is simply not served.

Decomposition:
- Package mux_arb_pkg holds:
  - the state encoding (IDLE=2'b00, GX=2'b01, GY=2'b10);
  - the localparams SIDE_X=0 and SIDE_Y=1 used for last.
- One sub-module, mux2_nbit (parameter N; ports s, X, Y, M), implements the per-bit AND-OR select.
- mux_arbiter holds the FSM, hold counter, last flag and valid gating around it.

Test Plan:
1. Reset, then req_x=1 only, X=4'hA -> gnt_x=1 and s=0 one edge later; M=4'hA and valid=1 persist; after MAX_HOLD=4 cycles gnt_x stays 1 (re-grant, no gap).
2. From IDLE, req_x=req_y=1 on the same edge, X=4'h3, Y=4'hC:
   - Cycles 1-4: gnt_x=1, M=4'h3.
   - Cycles 5-8: gnt_y=1, s=1, M=4'hC.
   - Then back to X; no idle cycle between owners.
3. gnt_y held with req_y=1; drop req_y while raising req_x on the same edge -> next edge gnt_x=1, gnt_y=0, M=X.
4. Drop the owner's request with the other side idle -> next edge state IDLE, valid=0, M=4'h0 even though X=4'hF.
5. Assert Resetn=0 mid-grant, between clock edges -> gnt_x/gnt_y/valid go 0 and M=0 immediately. After release with both requesting, X is granted first.
6. With MAX_HOLD=1 and both requesting continuously -> gnt_x and gnt_y alternate every cycle; s toggles each cycle.
